data_mem_pipe: RTL and testbench
================================

Name: data_mem_pipe

Overview:
Parametrised successor to the single-port byte data memory. Generalises data width, depth and read latency, and adds:
- an explicit read/idle/write command encoding;
- a read-valid strobe;
- a post-reset clear sequence that zeroes every location;
- out-of-range and illegal-command detection.

Sits between the processor datapath (load/store stage) and image storage; the datapath must honour busy and d_valid.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 19, address width in bits
DEPTH, 262145, number of words; must satisfy DEPTH <= 2**ADDR_W
READ_LAT, 1, read latency in cycles; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear sequence

Ports:
clk  input  1  clock; all activity on rising edge
rst_n  input  1  synchronous active-low reset
dAddr  input  ADDR_W  word address
d_in  input  DATA_W  write data
MEM_WRITE  input  2  command: 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 illegal
d_out  output  DATA_W  read data, registered
d_valid  output  1  one-cycle pulse; d_out holds new read data this cycle
busy  output  1  high while clear sequence runs; commands ignored
err  output  1  one-cycle pulse on illegal command or out-of-range address

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - d_out=0, d_valid=0, err=0, read pipeline flushed, clear counter=0.
  - Next state is CLEAR if CLEAR_ON_RESET=1 (busy=1 from first post-reset cycle), else READY (busy=0).
  - Memory contents are not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle write 0 to mem[clr_cnt], clr_cnt++. After the cycle writing DEPTH-1, go to READY; busy falls the following cycle.
    - Clear takes exactly DEPTH cycles.
    - All commands in CLEAR are dropped silently: no write, no d_valid, no err.
  - READY: commands execute as below. No transition back except via reset.
- Write (2'b10, dAddr<DEPTH): mem[dAddr] <= d_in at that edge. d_out unchanged, no d_valid.
- Read (2'b01, dAddr<DEPTH):
  - Array read registered at the issue edge.
  - READ_LAT=1: d_out/d_valid update at issue edge +1 cycle.
  - READ_LAT=2: one extra output register stage.
  - Fully pipelined: one read accepted per cycle, back-to-back reads give back-to-back d_valid.
- Write after read to the same address: the read returns the old value, captured at the issue edge.
- Idle (2'b00): d_out holds its last value; d_valid=0.
- Out-of-range (dAddr>=DEPTH):
  - Write is ignored and err pulses.
  - Read returns 0 with normal latency and d_valid, and err pulses in the issue+1 cycle.
- Illegal command (2'b11): no memory action, no d_valid; err pulses in the issue+1 cycle.
- Reset during CLEAR restarts the clear from address 0.
- Reset with reads in flight: pending d_valid pulses are discarded.
- Widths: clr_cnt is ADDR_W bits. The DEPTH comparison is unsigned, done at ADDR_W+1 bits to avoid overflow when DEPTH=2**ADDR_W.

Decomposition:
- Shared package holds:
  - MEM_WRITE encodings (CMD_IDLE, CMD_READ, CMD_WRITE, CMD_ILLEGAL);
  - FSM state typedef (ST_CLEAR, ST_READY).
- One sub-module is natural: ram_sp_core, a plain synchronous single-port array (DATA_W, DEPTH), with one write port and a registered read.
  - Top level owns the FSM, clear counter, address check, latency pipeline and err generation.
  - Clear writes are muxed onto the core's write port.

Test Plan:
- DEPTH=16, DATA_W=8, CLEAR_ON_RESET=1:
  - Release reset; busy=1 for exactly 16 cycles, then 0.
  - Read all 16 addresses: every d_out=8'h00 with d_valid.
  - During CLEAR, issue write 8'hAA to addr 3; after clear, read addr 3 -> 8'h00 and no err.
- READ_LAT=1: write 8'h5C to addr 7, then read addr 7 next cycle -> d_out=8'h5C, d_valid high exactly 1 cycle after the read. Repeat with READ_LAT=2 -> 2 cycles.
- Back-to-back reads of addrs 0,1,2 (preloaded 8'h11,8'h22,8'h33) -> three consecutive d_valid cycles carrying 8'h11,8'h22,8'h33 in order. Idle afterwards -> d_out stays 8'h33.
- Read addr 20 (DEPTH=16) -> d_out=0, d_valid=1, err=1 for one cycle. Write 8'hFF to addr 20 -> err=1 and no array word changes. MEM_WRITE=2'b11 -> err pulse, no d_valid.
- Assert rst_n=0 at clear-counter value 9, then release -> busy high for a full 16 cycles again.
- Assert reset while 2 reads are in flight (READ_LAT=2) -> no d_valid after reset.

Source files
------------

// File: rtl/data_mem_pipe_pkg.sv
// Shared definitions for the data_mem_pipe block.
// Contents:
//   cmd_e   - encoding of the MEM_WRITE command bus
//   state_e - top-level sequencer states (post-reset clear, normal operation)
package data_mem_pipe_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_READ    = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_pipe_ram_sp_core.sv
// Plain synchronous single-port word array with a registered read.
// Ports:
//   clk   - clock, all activity on the rising edge
//   rst_n - synchronous active-low reset; clears only the read register
//   we    - write enable; wdata is stored at addr
//   re    - read enable; mem[addr] is captured into rdata
//   rzero - load zero into rdata (out-of-range read); wins over re
//   addr  - word address; the caller guarantees addr < DEPTH when we/re is set
//   wdata - write data
//   rdata - registered read data, holds its value when no read is issued
module data_mem_pipe_ram_sp_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 262145,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              rzero,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0]  idx_s;

  // Only the low bits index the array; upper bits are zero for legal accesses.
  assign idx_s = addr[IDX_W-1:0];

  if (IDX_W < ADDR_W) begin : g_hi_bits
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^addr[ADDR_W-1:IDX_W];
  end

  // Array write port; the contents themselves are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Registered read port with zero-load for out-of-range reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rzero) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[idx_s];
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Parametrised single-port data memory for the load/store stage.
// Ports:
//   clk       - clock, all activity on the rising edge
//   rst_n     - synchronous active-low reset
//   dAddr     - word address
//   d_in      - write data
//   MEM_WRITE - command: 00 idle, 01 read, 10 write, 11 illegal
//   d_out     - registered read data, holds between reads
//   d_valid   - one-cycle pulse when d_out carries new read data
//   busy      - high while the post-reset clear runs; commands are dropped
//   err       - one-cycle pulse on illegal command or out-of-range address
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 19,
  parameter int DEPTH          = 262145,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [1:0]        MEM_WRITE,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              busy,
  output logic              err
);

  // Range checks use one extra bit so DEPTH == 2**ADDR_W does not overflow.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = DEPTH_X - (ADDR_W+1)'(1'b1);

  state_e            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              busy_r;
  logic              rd_v1_r;
  logic              err_r;

  cmd_e              cmd_s;
  logic              in_range_s;
  logic              core_we_s;
  logic              core_re_s;
  logic              core_rz_s;
  logic [ADDR_W-1:0] core_addr_s;
  logic [DATA_W-1:0] core_wdata_s;
  logic [DATA_W-1:0] core_rdata_s;
  logic              rd_issue_s;
  logic              err_set_s;

  assign cmd_s      = cmd_e'(MEM_WRITE);
  assign in_range_s = ({1'b0, dAddr} < DEPTH_X);

  // Command decode; during clear the write port is taken by the clear counter.
  always_comb begin
    core_we_s    = 1'b0;
    core_re_s    = 1'b0;
    core_rz_s    = 1'b0;
    core_addr_s  = dAddr;
    core_wdata_s = d_in;
    rd_issue_s   = 1'b0;
    err_set_s    = 1'b0;
    if (state_r == ST_CLEAR) begin
      core_we_s    = 1'b1;
      core_addr_s  = clr_cnt_r;
      core_wdata_s = '0;
    end else begin
      case (cmd_s)
        CMD_READ: begin
          rd_issue_s = 1'b1;
          if (in_range_s) begin
            core_re_s = 1'b1;
          end else begin
            core_rz_s = 1'b1;
            err_set_s = 1'b1;
          end
        end
        CMD_WRITE: begin
          if (in_range_s) begin
            core_we_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end
        CMD_ILLEGAL: err_set_s  = 1'b1;
        CMD_IDLE:    rd_issue_s = 1'b0;
        default:     err_set_s  = 1'b0;
      endcase
    end
  end

  // Sequencer: clear counter, busy, first read-valid stage and err pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      busy_r    <= (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
      clr_cnt_r <= '0;
      rd_v1_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rd_v1_r <= rd_issue_s;
      err_r   <= err_set_s;
      case (state_r)
        ST_CLEAR: begin
          // Stop at the last word rather than wrapping the counter.
          if ({1'b0, clr_cnt_r} == LAST_X) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1'b1);
          end
        end
        ST_READY: busy_r <= 1'b0;
        default: begin
          state_r <= ST_READY;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  data_mem_pipe_ram_sp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we_s),
    .re    (core_re_s),
    .rzero (core_rz_s),
    .addr  (core_addr_s),
    .wdata (core_wdata_s),
    .rdata (core_rdata_s)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d_out2_r;
    logic              d_valid2_r;

    // Extra output register stage for the two-cycle read latency.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d_out2_r   <= '0;
        d_valid2_r <= 1'b0;
      end else begin
        d_valid2_r <= rd_v1_r;
        if (rd_v1_r) begin
          d_out2_r <= core_rdata_s;
        end
      end
    end

    assign d_out   = d_out2_r;
    assign d_valid = d_valid2_r;
  end else begin : g_lat1
    // The core's read register is already the output register.
    assign d_out   = core_rdata_s;
    assign d_valid = rd_v1_r;
  end

  assign busy = busy_r;
  assign err  = err_r;

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;
  import data_mem_pipe_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] d_in;
  logic [1:0]    MEM_WRITE;
  logic [DW-1:0] d_out0, d_out1;
  logic          d_valid0, d_valid1, busy0, busy1, err0, err1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  // Lane 0: READ_LAT=1 instance, lane 1: READ_LAT=2 instance.
  exp_t dq[2][$];
  int   eq[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .dAddr(dAddr), .d_in(d_in), .MEM_WRITE(MEM_WRITE),
    .d_out(d_out0), .d_valid(d_valid0), .busy(busy0), .err(err0));

  data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .dAddr(dAddr), .d_in(d_in), .MEM_WRITE(MEM_WRITE),
    .d_out(d_out1), .d_valid(d_valid1), .busy(busy1), .err(err1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for one lane: pops expectations as outputs appear.
  task automatic mon(input int ln, input logic dv, input logic [7:0] dout, input logic er);
    exp_t e;
    int   ec;
    if (dv) begin
      if (dq[ln].size() == 0) begin
        checks++; errors++;
        $display("FAIL dvalid_unexpected lane%0d cycle %0d actual d_valid=1 d_out=%0h required d_valid=0", ln, cyc, dout);
      end else begin
        e = dq[ln].pop_front();
        chk($sformatf("rd_data_lane%0d", ln), 32'(dout), 32'(e.data));
        chk($sformatf("rd_latency_lane%0d", ln), cyc, e.cyc);
      end
    end else if (dq[ln].size() > 0 && dq[ln][0].cyc <= cyc) begin
      e = dq[ln].pop_front();
      checks++; errors++;
      $display("FAIL dvalid_missing lane%0d cycle %0d actual d_valid=0 required d_valid=1 data %0h", ln, cyc, e.data);
    end
    if (er) begin
      if (eq[ln].size() == 0) begin
        checks++; errors++;
        $display("FAIL err_unexpected lane%0d cycle %0d actual err=1 required err=0", ln, cyc);
      end else begin
        ec = eq[ln].pop_front();
        chk($sformatf("err_cycle_lane%0d", ln), cyc, ec);
      end
    end else if (eq[ln].size() > 0 && eq[ln][0] <= cyc) begin
      ec = eq[ln].pop_front();
      checks++; errors++;
      $display("FAIL err_missing lane%0d cycle %0d actual err=0 required err=1", ln, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, d_valid0, d_out0, err0);
    mon(1, d_valid1, d_out1, err1);
  end

  // Drive one command for one cycle and record what each lane must produce.
  task automatic issue(input logic [1:0] c, input logic [AW-1:0] a, input logic [7:0] d,
                       input bit [1:0] dvm, input logic [7:0] ed, input bit er);
    exp_t e;
    @(negedge clk);
    MEM_WRITE = c; dAddr = a; d_in = d;
    e.data = ed;
    if (dvm[0]) begin e.cyc = cyc + 1; dq[0].push_back(e); end
    if (dvm[1]) begin e.cyc = cyc + 2; dq[1].push_back(e); end
    if (er) begin eq[0].push_back(cyc + 1); eq[1].push_back(cyc + 1); end
  endtask

  // Called at a negedge while in reset: release and count busy cycles.
  task automatic release_and_count(input bit poke);
    int n0 = 0;
    int n1 = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (poke && i == 14) begin
        MEM_WRITE = CMD_WRITE; dAddr = 5'd3; d_in = 8'hAA;
      end else begin
        MEM_WRITE = CMD_IDLE;
      end
      if (!busy0 && !busy1) break;
      if (busy0) n0++;
      if (busy1) n1++;
      @(negedge clk);
    end
    chk("busy_cycles_lane0", n0, 16);
    chk("busy_cycles_lane1", n1, 16);
  endtask

  initial begin
    int total;
    rst_n = 1'b0; MEM_WRITE = CMD_IDLE; dAddr = '0; d_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_out_lane0", 32'(d_out0), 32'h0);
    chk("rst_d_out_lane1", 32'(d_out1), 32'h0);
    chk("rst_d_valid_lane0", 32'(d_valid0), 32'h0);
    chk("rst_d_valid_lane1", 32'(d_valid1), 32'h0);
    chk("rst_err_lane0", 32'(err0), 32'h0);
    chk("rst_busy_lane0", 32'(busy0), 32'h1);
    chk("rst_busy_lane1", 32'(busy1), 32'h1);
    release_and_count(1'b0);

    // Fill with non-zero data so the next clear is observable.
    for (int a = 0; a < DP; a++) issue(CMD_WRITE, 5'(a), 8'hC0 | 8'(a), 2'b00, 8'h00, 1'b0);
    issue(CMD_READ, 5'd5, 8'h00, 2'b11, 8'hC5, 1'b0);
    issue(CMD_IDLE, 5'd0, 8'h00, 2'b00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset, then abort the clear when the counter reaches 9.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    chk("busy_before_abort_lane0", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    release_and_count(1'b1);

    // Every word cleared, including the one written during clear.
    for (int a = 0; a < DP; a++) issue(CMD_READ, 5'(a), 8'h00, 2'b11, 8'h00, 1'b0);

    // Write then read next cycle; write-after-read returns old value.
    issue(CMD_WRITE, 5'd7, 8'h5C, 2'b00, 8'h00, 1'b0);
    issue(CMD_READ,  5'd7, 8'h00, 2'b11, 8'h5C, 1'b0);
    issue(CMD_WRITE, 5'd7, 8'h99, 2'b00, 8'h00, 1'b0);
    issue(CMD_READ,  5'd7, 8'h00, 2'b11, 8'h99, 1'b0);

    // Back-to-back reads then idle hold.
    issue(CMD_WRITE, 5'd0, 8'h11, 2'b00, 8'h00, 1'b0);
    issue(CMD_WRITE, 5'd1, 8'h22, 2'b00, 8'h00, 1'b0);
    issue(CMD_WRITE, 5'd2, 8'h33, 2'b00, 8'h00, 1'b0);
    issue(CMD_READ,  5'd0, 8'h00, 2'b11, 8'h11, 1'b0);
    issue(CMD_READ,  5'd1, 8'h00, 2'b11, 8'h22, 1'b0);
    issue(CMD_READ,  5'd2, 8'h00, 2'b11, 8'h33, 1'b0);
    issue(CMD_IDLE,  5'd0, 8'h00, 2'b00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle_hold_lane0", 32'(d_out0), 32'h33);
    chk("idle_hold_lane1", 32'(d_out1), 32'h33);

    // Out-of-range read/write and illegal command.
    issue(CMD_READ,    5'd20, 8'h00, 2'b11, 8'h00, 1'b1);
    issue(CMD_WRITE,   5'd20, 8'hFF, 2'b00, 8'h00, 1'b1);
    issue(CMD_READ,    5'd4,  8'h00, 2'b11, 8'h00, 1'b0);
    issue(CMD_ILLEGAL, 5'd1,  8'h00, 2'b00, 8'h00, 1'b1);
    issue(CMD_IDLE,    5'd0,  8'h00, 2'b00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset with reads in flight: the second read never appears on lane 1.
    issue(CMD_READ, 5'd0, 8'h00, 2'b11, 8'h11, 1'b0);
    issue(CMD_READ, 5'd1, 8'h00, 2'b01, 8'h22, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; MEM_WRITE = CMD_IDLE;
    @(negedge clk);
    release_and_count(1'b0);
    issue(CMD_READ, 5'd2, 8'h00, 2'b11, 8'h00, 1'b0);
    issue(CMD_IDLE, 5'd0, 8'h00, 2'b00, 8'h00, 1'b0);

    total = 1;
    for (int i = 0; i < 20 && total > 0; i++) begin
      @(negedge clk);
      total = dq[0].size() + dq[1].size() + eq[0].size() + eq[1].size();
    end
    chk("scoreboard_drained", total, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
